// File: rtl/data_mem_ctrl.sv
// Single-port 64-bit data memory controller with request/response handshakes.
// Each access passes through IDLE -> ACCESS -> RESP; bad addresses report rsp_err.
module data_mem_ctrl #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IDX_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state, state_next;

  logic              wr_q;
  logic [63:0]       addr_q;
  logic [63:0]       wdata_q;
  logic [63:0]       mem [DEPTH];

  logic              accept_c;
  logic              mem_we_c;
  logic              acc_err_c;
  logic [IDX_W-1:0]  idx_c;

  // Misaligned, or any address bit above the word index is set (word >= DEPTH)
  assign idx_c     = addr_q[IDX_W+2:3];
  assign acc_err_c = (addr_q[2:0] != 3'd0) || (|addr_q[63:IDX_W+3]);

  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    mem_we_c   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept_c   = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        mem_we_c   = wr_q && !acc_err_c;
        state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State plus status outputs registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      state     <= state_next;
      req_ready <= (state_next == IDLE);
      busy      <= (state_next != IDLE);
      rsp_valid <= (state_next == RESP);
    end
  end

  // Request capture and response data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q      <= 1'b0;
      addr_q    <= 64'd0;
      wdata_q   <= 64'd0;
      rsp_rdata <= 64'd0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept_c) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == ACCESS) begin
        rsp_err   <= acc_err_c;
        rsp_rdata <= (wr_q || acc_err_c) ? 64'd0 : mem[idx_c];
      end
    end
  end

  // Array has no reset so contents survive rst_n
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[idx_c] <= wdata_q;
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed vectors, corner sequences,
// and random traffic against an array-based memory model.
module tb_data_mem_ctrl;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned IDX_W = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [63:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err, busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] ref_mem [DEPTH];

  typedef struct {
    string       name;
    bit          w;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t tbl [14];

  data_mem_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected response from the address rules; updates the model on good stores
  task automatic model(input bit w, input logic [63:0] a, input logic [63:0] d,
                       output logic [63:0] rd, output bit er);
    logic [63:0] word;
    word = a >> 3;
    er = (a % 8 != 0) || (word >= 64'(DEPTH));
    rd = 64'd0;
    if (!er) begin
      if (w) ref_mem[int'(word)] = d;
      else   rd = ref_mem[int'(word)];
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!req_ready && n < 20) begin step(); n++; end
    if (!req_ready) check("req_ready_timeout", 64'(req_ready), 64'd1);
  endtask

  // Full transaction with optional response stall and input scrambling after accept
  task automatic transact(input bit w, input logic [63:0] a, input logic [63:0] d,
                          input int stall, output logic [63:0] rd, output bit er);
    logic [63:0] held;
    wait_idle();
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    step();
    req_valid = 1'b0; req_write = ~w;
    req_addr  = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    check("access_no_rsp", 64'(rsp_valid), 64'd0);
    rsp_ready = (stall == 0);
    step();
    check("lat_rsp_valid", 64'(rsp_valid), 64'd1);
    held = rsp_rdata;
    for (int i = 0; i < stall; i++) begin
      step();
      check("stall_valid", 64'(rsp_valid), 64'd1);
      check("stall_rdata", rsp_rdata, held);
    end
    rd = rsp_rdata; er = rsp_err;
    rsp_ready = 1'b1;
    step();
    check("rsp_done", 64'(rsp_valid), 64'd0);
  endtask

  task automatic run_model(input bit w, input logic [63:0] a, input logic [63:0] d,
                           input int stall, input string tag);
    logic [63:0] rd, erd;
    bit er, eer;
    transact(w, a, d, stall, rd, er);
    model(w, a, d, erd, eer);
    check({tag, "_rdata"}, rd, erd);
    check({tag, "_err"}, 64'(er), 64'(eer));
  endtask

  initial begin
    logic [63:0] rd, held;
    bit er;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = 64'd0; req_wdata = 64'd0; rsp_ready = 1'b1;

    #12;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_rsp_rdata", rsp_rdata, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    step();

    // Give every word a known value
    for (int i = 0; i < int'(DEPTH); i++)
      run_model(1'b1, 64'(i) << 3, {$urandom, $urandom}, 0, "init");

    tbl[0]  = '{"st_10",     1, 64'h10, 64'hDEADBEEF_CAFEF00D, 64'd0, 0};
    tbl[1]  = '{"ld_10",     0, 64'h10, 64'd0, 64'hDEADBEEF_CAFEF00D, 0};
    tbl[2]  = '{"st_08",     1, 64'h08, 64'h1111_2222_3333_4444, 64'd0, 0};
    tbl[3]  = '{"ld_0c",     0, 64'h0C, 64'd0, 64'd0, 1};
    tbl[4]  = '{"st_0c",     1, 64'h0C, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
    tbl[5]  = '{"ld_08",     0, 64'h08, 64'd0, 64'h1111_2222_3333_4444, 0};
    tbl[6]  = '{"ld_10b",    0, 64'h10, 64'd0, 64'hDEADBEEF_CAFEF00D, 0};
    tbl[7]  = '{"st_00",     1, 64'h00, 64'h5A5A_5A5A_5A5A_5A5A, 64'd0, 0};
    tbl[8]  = '{"st_200",    1, 64'h200, 64'h0BAD, 64'd0, 1};
    tbl[9]  = '{"ld_00",     0, 64'h00, 64'd0, 64'h5A5A_5A5A_5A5A_5A5A, 0};
    tbl[10] = '{"st_1f8",    1, 64'h1F8, 64'h0123_4567_89AB_CDEF, 64'd0, 0};
    tbl[11] = '{"ld_1f8",    0, 64'h1F8, 64'd0, 64'h0123_4567_89AB_CDEF, 0};
    tbl[12] = '{"ld_200",    0, 64'h200, 64'd0, 64'd0, 1};
    tbl[13] = '{"ld_hibit",  0, 64'h8000_0000_0000_0000, 64'd0, 64'd0, 1};

    foreach (tbl[i]) begin
      logic [63:0] mrd;
      bit mer;
      transact(tbl[i].w, tbl[i].addr, tbl[i].wdata, 0, rd, er);
      model(tbl[i].w, tbl[i].addr, tbl[i].wdata, mrd, mer);
      check({tbl[i].name, "_rdata"}, rd, tbl[i].exp_rdata);
      check({tbl[i].name, "_err"}, 64'(er), 64'(tbl[i].exp_err));
    end

    // Response stalled five cycles; a request pulse during RESP is ignored
    wait_idle();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h10;
    step();
    req_valid = 1'b0; rsp_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h10; req_wdata = 64'd0;
      end else req_valid = 1'b0;
      check("hold_valid", 64'(rsp_valid), 64'd1);
      check("hold_rdata", rsp_rdata, 64'hDEADBEEF_CAFEF00D);
      check("hold_req_ready", 64'(req_ready), 64'd0);
      step();
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    step();
    check("hold_release_idle", 64'(busy), 64'd0);
    check("hold_release_ready", 64'(req_ready), 64'd1);
    check("retain_rdata", rsp_rdata, 64'hDEADBEEF_CAFEF00D);
    run_model(1'b0, 64'h10, 64'd0, 0, "after_pulse");

    // Reset during a store's ACCESS cycle
    run_model(1'b1, 64'h18, 64'hAA, 0, "pre_st3");
    run_model(1'b0, 64'h18, 64'd0, 0, "pre_ld3");
    wait_idle();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h18; req_wdata = 64'h55;
    step();
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_ready", 64'(req_ready), 64'd1);
    check("mid_rst_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_rdata", rsp_rdata, 64'd0);
    check("mid_rst_err", 64'(rsp_err), 64'd0);
    step();
    #2 rst_n = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h18;
    step();
    req_valid = 1'b0;
    check("post_rst_accept", 64'(busy), 64'd1);
    step();
    check("post_rst_rdata", rsp_rdata, 64'hAA);
    step();

    // Back-to-back loads: one accept every three cycles
    wait_idle();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h10;
    for (int k = 0; k < 10; k++) begin
      check("b2b_busy", 64'(busy), 64'(k % 3 != 0));
      check("b2b_ready", 64'(req_ready), 64'(k % 3 == 0));
      check("b2b_valid", 64'(rsp_valid), 64'(k % 3 == 2));
      if (k % 3 == 2) check("b2b_rdata", rsp_rdata, ref_mem[2]);
      if (k == 9) req_valid = 1'b0;
      step();
    end
    step(); step();

    // Random traffic, mostly legal words with some misaligned/out-of-range
    for (int i = 0; i < 200; i++) begin
      logic [63:0] a;
      int sel = int'($urandom_range(0, 9));
      if (sel < 7)       a = 64'($urandom_range(0, DEPTH - 1)) << 3;
      else if (sel == 7) a = (64'($urandom_range(0, DEPTH - 1)) << 3) | 64'($urandom_range(1, 7));
      else if (sel == 8) a = 64'($urandom_range(DEPTH, 4 * DEPTH)) << 3;
      else               a = {$urandom, $urandom};
      run_model(1'($urandom), a, {$urandom, $urandom}, int'($urandom_range(0, 2)), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
